// File: rtl/coherent_sampler_counter.sv
// coherent_sampler_counter
//   Measures the beat period of a coherent-sampling flip-flop output and hands
//   each new period to a downstream controller through a REQ/ACK handshake.
//   Periods that arrive while the handshake is busy are counted as drops.
//
// Ports
//   clk      in   sampling clock; everything runs on its rising edge
//   rst_n    in   asynchronous active-low reset
//   ROSample in   raw coherent-sampling flip-flop output
//   CSAck    in   acknowledge from the downstream controller
//   CSCnt    out  latest captured beat period in clk cycles (saturating)
//   CSReq    out  high while CSCnt holds an unacknowledged value
//   CSBit    out  raw random bit, CSCnt[0]
//   dropCnt  out  saturating count of periods lost to a busy handshake
module coherent_sampler_counter #(
  parameter int CSCntLength = 16,
  parameter int FiltLen     = 2,
  parameter int DropLength  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ROSample,
  input  logic                   CSAck,
  output logic [CSCntLength-1:0] CSCnt,
  output logic                   CSReq,
  output logic                   CSBit,
  output logic [DropLength-1:0]  dropCnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic                   s_in_reg;
  logic [FiltLen-1:0]     hist_reg;
  logic [CSCntLength-1:0] per_cnt_reg;
  logic                   first_seen_reg;
  logic                   acc_edge;
  logic                   capture;
  logic                   drop;

  // Input is registered once; the filter and edge logic only ever see s_in_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_in_reg <= 1'b0;
    end else begin
      s_in_reg <= ROSample;
    end
  end

  // hist_reg holds the FiltLen sIn values preceding the current one.
  generate
    if (FiltLen == 1) begin : g_hist1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist_reg <= '0;
        end else begin
          hist_reg <= s_in_reg;
        end
      end
    end else begin : g_histn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist_reg <= '0;
        end else begin
          hist_reg <= {hist_reg[FiltLen-2:0], s_in_reg};
        end
      end
    end
  endgenerate

  // A rising edge is accepted only after a full low run of FiltLen samples.
  assign acc_edge = s_in_reg & ~(|hist_reg);

  // per_cnt_reg is loaded with 1 on the cycle after an edge, so at the next
  // edge it equals the distance between the two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_reg    <= '0;
      first_seen_reg <= 1'b0;
    end else if (acc_edge) begin
      per_cnt_reg    <= CSCntLength'(1);
      first_seen_reg <= 1'b1;
    end else if (per_cnt_reg != {CSCntLength{1'b1}}) begin
      per_cnt_reg    <= per_cnt_reg + CSCntLength'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        // The very first edge only arms the period measurement.
        if (acc_edge && first_seen_reg) begin
          capture    = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        drop = acc_edge;
        if (CSAck) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        drop = acc_edge;
        if (!CSAck) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CSCnt <= '0;
    end else if (capture) begin
      CSCnt <= per_cnt_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropCnt <= '0;
    end else if (drop && (dropCnt != {DropLength{1'b1}})) begin
      dropCnt <= dropCnt + DropLength'(1);
    end
  end

  assign CSReq = (state_reg == REQ);
  assign CSBit = CSCnt[0];

endmodule

// File: tb/tb_coherent_sampler_counter.sv
// Testbench for coherent_sampler_counter: directed waveforms on ROSample, a
// queue of expected capture values filled as each edge is driven and drained
// whenever CSReq rises.
module tb_coherent_sampler_counter;

  logic        clk;
  logic        rst_n;
  logic        ro;
  logic        cs_ack;
  logic        auto_ack_sig;
  logic        man_ack;
  logic [15:0] cs_cnt;
  logic        cs_req;
  logic        cs_bit;
  logic [7:0]  drop_cnt;

  int          checks = 0;
  int          errors = 0;
  bit          auto_on = 1'b0;
  int          last_hi = 0;
  logic [15:0] exp_q[$];

  assign cs_ack = auto_ack_sig | man_ack;

  coherent_sampler_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ROSample (ro),
    .CSAck    (cs_ack),
    .CSCnt    (cs_cnt),
    .CSReq    (cs_req),
    .CSBit    (cs_bit),
    .dropCnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v);
    @(posedge clk);
    #1;
    ro = v;
  endtask

  // Low for lo cycles, then high for hi cycles; the rising edge's period is
  // the previous high time plus this low time.
  task automatic wave(input int lo, input int hi, input bit cap);
    int p;
    p = last_hi + lo;
    if (cap) exp_q.push_back((p > 65535) ? 16'hFFFF : p[15:0]);
    repeat (lo) step(1'b0);
    repeat (hi) step(1'b1);
    last_hi = hi;
  endtask

  // Same as wave but the high phase carries a one-cycle low glitch.
  task automatic wave_glitch(input int lo, input bit cap);
    int p;
    p = last_hi + lo;
    if (cap) exp_q.push_back(p[15:0]);
    repeat (lo) step(1'b0);
    repeat (2) step(1'b1);
    step(1'b0);
    repeat (2) step(1'b1);
    last_hi = 5;
  endtask

  // Reset asserted between clock edges; outputs are checked before any edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_cscnt"}, cs_cnt, 0);
    check({tag, "_csreq"}, cs_req, 0);
    check({tag, "_csbit"}, cs_bit, 0);
    check({tag, "_drop"}, drop_cnt, 0);
    ro = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_hi = 0;
  endtask

  // Scoreboard: every CSReq rise must match the oldest expected value.
  initial begin
    logic        prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cs_req && !prev) begin
        check("capture_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("cscnt", cs_cnt, e);
          check("csbit", cs_bit, e[0]);
          $display("capture cscnt=%0d csbit=%0d drop=%0d exp=%0d", cs_cnt, cs_bit, drop_cnt, e);
        end
      end
      prev = cs_req;
    end
  end

  // Auto responder: one-cycle ack, one cycle after CSReq rises.
  initial begin
    logic rprev;
    rprev = 1'b0;
    auto_ack_sig = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_on && cs_req && !rprev) begin
        rprev = 1'b1;
        @(posedge clk);
        #1 auto_ack_sig = 1'b1;
        @(posedge clk);
        #1 auto_ack_sig = 1'b0;
      end else begin
        rprev = cs_req;
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    ro      = 1'b0;
    man_ack = 1'b0;

    // Square wave 5/5 with auto ack: every capture is 10.
    do_reset("rst0");
    auto_on = 1'b1;
    wave(5, 5, 1'b0);
    repeat (5) wave(5, 5, 1'b1);
    // Glitch inside a high phase adds no edge.
    wave_glitch(5, 1'b1);
    wave(5, 5, 1'b1);
    repeat (4) step(1'b0);
    check("sq_drop", drop_cnt, 0);
    check("sq_q_empty", exp_q.size(), 0);

    // Period 12, never acknowledged: one capture then three drops.
    do_reset("rst1");
    auto_on = 1'b0;
    wave(6, 6, 1'b0);
    wave(6, 6, 1'b1);
    repeat (3) wave(6, 6, 1'b0);
    repeat (3) step(1'b0);
    check("noack_cscnt", cs_cnt, 12);
    check("noack_csreq", cs_req, 1);
    check("noack_drop", drop_cnt, 3);
    check("noack_q_empty", exp_q.size(), 0);

    // Long low run saturates the period, then a normal period follows.
    do_reset("rst2");
    auto_on = 1'b1;
    wave(3, 5, 1'b0);
    wave(70000, 5, 1'b1);
    wave(5, 5, 1'b1);
    repeat (4) step(1'b0);
    check("sat_q_empty", exp_q.size(), 0);
    check("sat_drop", drop_cnt, 0);

    // Edge coincident with ack in REQ is dropped; the next edge captures.
    do_reset("rst3");
    auto_on = 1'b0;
    wave(5, 5, 1'b0);
    wave(5, 5, 1'b1);
    repeat (4) step(1'b0);
    step(1'b1);
    step(1'b1);
    man_ack = 1'b1;
    step(1'b1);
    man_ack = 1'b0;
    repeat (2) step(1'b1);
    last_hi = 5;
    check("coinc_drop", drop_cnt, 1);
    check("coinc_cscnt", cs_cnt, 10);
    check("coinc_csreq", cs_req, 0);
    wave(9, 5, 1'b1);
    repeat (3) step(1'b0);
    check("coinc_next_req", cs_req, 1);
    check("coinc_drop2", drop_cnt, 1);
    check("coinc_q_empty", exp_q.size(), 0);

    // Reset during REQ aborts; first edge after release only re-arms.
    check("pre_rst_req", cs_req, 1);
    do_reset("rst4");
    wave(5, 5, 1'b0);
    check("rearm_csreq", cs_req, 0);
    check("rearm_cscnt", cs_cnt, 0);
    wave(5, 5, 1'b1);
    repeat (3) step(1'b0);
    check("rearm_req2", cs_req, 1);
    check("rearm_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
